// File: rtl/register_file_sb_pkg.sv
// Shared constants and address helpers for the pipelined register file and its scoreboard.
package register_file_sb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO       = 0;

    // An address is "live" unless it is the hardwired zero register.
    function automatic logic addr_live(input logic [31:0] addr, input bit zero_reg);
        return !(zero_reg && addr == 32'(REG_ZERO));
    endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue claims and cleared by writeback.
module register_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      claim_en,
    input  logic [ADDR_WIDTH-1:0]     claim_addr,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [2**ADDR_WIDTH-1:0]  busy,
    output logic [ADDR_WIDTH:0]       busy_count,
    output logic                      wr_unclaimed
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic              unclaimed_q, unclaimed_d;
    logic              wr_live, claim_live;

    assign wr_live    = wr_en    && addr_live(32'(wr_addr), ZERO_REG);
    assign claim_live = claim_en && addr_live(32'(claim_addr), ZERO_REG);

    always_comb begin
        busy_d = busy_q;
        // Release first so a same-address claim (the newer producer) wins.
        if (wr_live)    busy_d[wr_addr]    = 1'b0;
        if (claim_live) busy_d[claim_addr] = 1'b1;
        count_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            count_d = count_d + (ADDR_WIDTH+1)'(busy_d[r]);
        end
        unclaimed_d = unclaimed_q |
                      (wr_live && !busy_q[wr_addr] && !(claim_live && claim_addr == wr_addr));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q      <= '0;
            count_q     <= '0;
            unclaimed_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            count_q     <= count_d;
            unclaimed_q <= unclaimed_d;
        end
    end

    assign busy         = busy_q;
    assign busy_count   = count_q;
    assign wr_unclaimed = unclaimed_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with writeback bypass and a pending-write scoreboard.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           claim_en,
    input  logic [ADDR_WIDTH-1:0]          claim_addr,
    output logic [ADDR_WIDTH:0]            busy_count,
    output logic                           wr_unclaimed
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Name kept stable so simulation preloads can target it hierarchically.
    logic [DATA_WIDTH-1:0] registers [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_live;

    assign wr_live = wr_en && addr_live(32'(wr_addr), ZERO_REG);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) registers[r] <= '0;
        end else if (wr_live) begin
            registers[wr_addr] <= wr_data;
        end
    end

    register_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .reset_n      (reset_n),
        .claim_en     (claim_en),
        .claim_addr   (claim_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .busy         (busy),
        .busy_count   (busy_count),
        .wr_unclaimed (wr_unclaimed)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  zero_hit, byp_hit;

        assign a        = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = ZERO_REG && a == ADDR_WIDTH'(REG_ZERO);
        assign byp_hit  = BYPASS && wr_en && wr_addr == a && !zero_hit;

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            zero_hit ? '0 : (byp_hit ? wr_data : registers[a]);
        assign rd_busy[i] = !zero_hit && !byp_hit && busy[a];
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: a bypassing and a non-bypassing instance share all inputs.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ra0, ra1;
    logic        wr_en, claim_en;
    logic [4:0]  wr_addr, claim_addr;
    logic [31:0] wr_data;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  cnt_a, cnt_b;
    logic        unc_a, unc_b;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    register_file_sb u_a (
        .clk(clk), .reset_n(reset_n), .rd_addr({ra1, ra0}), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_count(cnt_a),
        .wr_unclaimed(unc_a)
    );

    register_file_sb #(.BYPASS(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .rd_addr({ra1, ra0}), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_count(cnt_b),
        .wr_unclaimed(unc_b)
    );

    typedef struct {
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  busy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; claim_en = 1'b0; wr_addr = '0; claim_addr = '0; wr_data = '0;
    endtask

    task automatic claim(input logic [4:0] a);
        idle(); claim_en = 1'b1; claim_addr = a; tick(); idle();
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; tick(); idle();
    endtask

    initial begin
        vecs[0] = '{a0: 5'd1, a1: 5'd2, d0: 32'h14, d1: 32'h40, busy: 2'b00};
        vecs[1] = '{a0: 5'd6, a1: 5'd9, d0: 32'h32, d1: 32'h28, busy: 2'b00};
        vecs[2] = '{a0: 5'd0, a1: 5'd0, d0: 32'h0,  d1: 32'h0,  busy: 2'b00};
        vecs[3] = '{a0: 5'd2, a1: 5'd1, d0: 32'h40, d1: 32'h14, busy: 2'b00};
        vecs[4] = '{a0: 5'd9, a1: 5'd9, d0: 32'h28, d1: 32'h28, busy: 2'b00};

        reset_n = 1'b0; ra0 = '0; ra1 = '0; idle();
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("reset_count", 32'(cnt_a), 32'd0);
        chk("reset_unclaimed", 32'(unc_a), 32'd0);
        ra0 = 5'd1; #1;
        chk("reset_reg1", rd_data_a[31:0], 32'h0);

        // Preload by claim-then-write so the unclaimed flag stays clear.
        claim(5'd1); claim(5'd2); claim(5'd6); claim(5'd9);
        chk("preload_count4", 32'(cnt_a), 32'd4);
        write(5'd1, 32'h14); write(5'd2, 32'h40); write(5'd6, 32'h32); write(5'd9, 32'h28);
        chk("preload_count0", 32'(cnt_a), 32'd0);
        chk("preload_unclaimed", 32'(unc_a), 32'd0);

        for (int v = 0; v < 5; v++) begin
            ra0 = vecs[v].a0; ra1 = vecs[v].a1; #1;
            chk($sformatf("vec%0d_d0", v), rd_data_a[31:0], vecs[v].d0);
            chk($sformatf("vec%0d_d1", v), rd_data_a[63:32], vecs[v].d1);
            chk($sformatf("vec%0d_busy", v), 32'(rd_busy_a), 32'(vecs[v].busy));
            chk($sformatf("vec%0d_nobyp_d0", v), rd_data_b[31:0], vecs[v].d0);
        end

        // Same-cycle bypass vs. registered visibility.
        claim(5'd3);
        ra0 = 5'd3; ra1 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; #1;
        chk("byp_data", rd_data_a[31:0], 32'hDEADBEEF);
        chk("byp_busy", 32'(rd_busy_a[0]), 32'd0);
        chk("nobyp_old", rd_data_b[31:0], 32'h0);
        chk("nobyp_busy", 32'(rd_busy_b[0]), 32'd1);
        tick(); idle(); #1;
        chk("nobyp_new", rd_data_b[31:0], 32'hDEADBEEF);
        chk("byp_count0", 32'(cnt_a), 32'd0);

        // Claim then release of register 5.
        claim(5'd5);
        ra0 = 5'd5; #1;
        chk("claim5_busy", 32'(rd_busy_a[0]), 32'd1);
        chk("claim5_count", 32'(cnt_a), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; #1;
        chk("rel5_byp_busy", 32'(rd_busy_a[0]), 32'd0);
        chk("rel5_byp_data", rd_data_a[31:0], 32'h77);
        tick(); idle(); #1;
        chk("rel5_count", 32'(cnt_a), 32'd0);
        chk("rel5_unclaimed", 32'(unc_a), 32'd0);

        // Claim and write of the same register on one edge: claim wins.
        claim_en = 1'b1; claim_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        tick(); idle();
        ra0 = 5'd7; ra1 = 5'd7; #1;
        chk("cw7_data", rd_data_a[31:0], 32'h55);
        chk("cw7_busy", 32'(rd_busy_a), 32'b11);
        chk("cw7_port_eq", rd_data_a[63:32], 32'h55);
        chk("cw7_count", 32'(cnt_a), 32'd1);
        chk("cw7_unclaimed", 32'(unc_a), 32'd0);

        // Register zero ignores writes and claims.
        claim_en = 1'b1; claim_addr = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        ra0 = 5'd0; #1;
        chk("zero_byp", rd_data_a[31:0], 32'h0);
        tick(); idle(); #1;
        chk("zero_data", rd_data_a[31:0], 32'h0);
        chk("zero_busy", 32'(rd_busy_a[0]), 32'd0);
        chk("zero_count", 32'(cnt_a), 32'd1);
        chk("zero_unclaimed", 32'(unc_a), 32'd0);

        // Write to an unclaimed register sets the sticky flag.
        write(5'd4, 32'h99);
        chk("unc_set", 32'(unc_a), 32'd1);
        chk("unc_set_b", 32'(unc_b), 32'd1);
        tick();
        chk("unc_sticky", 32'(unc_a), 32'd1);

        // Reset mid-operation with writes and claims pending.
        claim(5'd1); claim(5'd2); claim(5'd3);
        chk("pre_rst_count", 32'(cnt_a), 32'd4);
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h123; claim_en = 1'b1; claim_addr = 5'd9;
        tick();
        reset_n = 1'b1; idle();
        ra0 = 5'd1; ra1 = 5'd9; #1;
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_count_b", 32'(cnt_b), 32'd0);
        chk("rst_unclaimed", 32'(unc_a), 32'd0);
        chk("rst_reg1", rd_data_a[31:0], 32'h0);
        chk("rst_reg9", rd_data_a[63:32], 32'h0);
        chk("rst_busy", 32'(rd_busy_a), 32'd0);
        ra0 = 5'd6; ra1 = 5'd7; #1;
        chk("rst_reg6", rd_data_a[31:0], 32'h0);
        chk("rst_busy7", 32'(rd_busy_a[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
